// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with cascade ci/tc, wrap/saturate mode and clamped loads.
// Optional match comparator enabled by defining BCD_COUNTER_MATCH_EN.
module bcd_counter_n #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  up,
    input  logic                  ci,
    input  logic [4*DIGITS-1:0]   d,
`ifdef BCD_COUNTER_MATCH_EN
    input  logic [4*DIGITS-1:0]   match_val,
    output logic                  match,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic                  co,
    output logic                  tc,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] q_r;
    logic [W-1:0] q_nxt;
    logic [W-1:0] q_step;
    logic [W-1:0] d_clamp;
    logic         any_bad;
    logic         all9;
    logic         all0;
    logic         term;
    logic         count_c;
    logic         load_c;
    logic         co_r;
    logic         load_err_r;

    // Clamp each loaded nibble to 9 and classify the current value.
    always_comb begin
        d_clamp = '0;
        any_bad = 1'b0;
        all9    = 1'b1;
        all0    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                d_clamp[4*i +: 4] = 4'd9;
                any_bad           = 1'b1;
            end else begin
                d_clamp[4*i +: 4] = d[4*i +: 4];
            end
            if (q_r[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (q_r[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    // Ripple one step through the digits; a digit moves only while all lower digits rolled over.
    always_comb begin
        logic carry;
        q_step = q_r;
        carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    carry             = (q_r[4*i +: 4] == 4'd9);
                    q_step[4*i +: 4]  = carry ? 4'd0 : q_r[4*i +: 4] + 4'd1;
                end else begin
                    carry             = (q_r[4*i +: 4] == 4'd0);
                    q_step[4*i +: 4]  = carry ? 4'd9 : q_r[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        term    = up ? all9 : all0;
        load_c  = enable & load;
        count_c = enable & ci & ~load;
        q_nxt   = q_r;
        if (load_c) begin
            q_nxt = d_clamp;
        end else if (count_c && !(term && !WRAP)) begin
            q_nxt = q_step;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r        <= '0;
            co_r       <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            q_r        <= q_nxt;
            co_r       <= count_c & term;
            load_err_r <= load_c ? any_bad : load_err_r;
        end
    end

`ifdef BCD_COUNTER_MATCH_EN
    // Compare against the value q takes at this edge so match lines up with q.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            match <= 1'b0;
        end else begin
            match <= (q_nxt == match_val);
        end
    end
`endif

    assign q        = q_r;
    assign co       = co_r;
    assign load_err = load_err_r;
    assign tc       = count_c & term;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n: wrap and saturate instances plus a 2x2-digit cascade.
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        clr;
    logic        enable, load, up, ci;
    logic [15:0] d;
    logic [15:0] w_q, s_q;
    logic        w_co, s_co, w_tc, s_tc, w_le, s_le;

    logic        c_en, c_up, c_load;
    logic [7:0]  c_dlo, c_dhi;
    logic [7:0]  lo_q, hi_q;
    logic        lo_co, hi_co, lo_tc, hi_tc, lo_le, hi_le;

`ifdef BCD_COUNTER_MATCH_EN
    logic [15:0] mv;
    logic        w_match, s_match, lo_match, hi_match;
    logic [7:0]  c_mlo, c_mhi;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut_w (
        .clk(clk), .clr(clr), .enable(enable), .load(load), .up(up), .ci(ci), .d(d),
`ifdef BCD_COUNTER_MATCH_EN
        .match_val(mv), .match(w_match),
`endif
        .q(w_q), .co(w_co), .tc(w_tc), .load_err(w_le));

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) dut_s (
        .clk(clk), .clr(clr), .enable(enable), .load(load), .up(up), .ci(ci), .d(d),
`ifdef BCD_COUNTER_MATCH_EN
        .match_val(mv), .match(s_match),
`endif
        .q(s_q), .co(s_co), .tc(s_tc), .load_err(s_le));

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_lo (
        .clk(clk), .clr(clr), .enable(c_en), .load(c_load), .up(c_up), .ci(1'b1), .d(c_dlo),
`ifdef BCD_COUNTER_MATCH_EN
        .match_val(c_mlo), .match(lo_match),
`endif
        .q(lo_q), .co(lo_co), .tc(lo_tc), .load_err(lo_le));

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_hi (
        .clk(clk), .clr(clr), .enable(c_en), .load(c_load), .up(c_up), .ci(lo_tc), .d(c_dhi),
`ifdef BCD_COUNTER_MATCH_EN
        .match_val(c_mhi), .match(hi_match),
`endif
        .q(hi_q), .co(hi_co), .tc(hi_tc), .load_err(hi_le));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (w_q !== 16'h0000) begin bad++; $display("FAIL reset_q act=%h exp=0000", w_q); end
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL reset_co act=%b exp=0", w_co); end
        total++; if (w_le !== 1'b0) begin bad++; $display("FAIL reset_le act=%b exp=0", w_le); end
        total++; if (w_tc !== 1'b0) begin bad++; $display("FAIL reset_tc act=%b exp=0", w_tc); end
        total++; if (s_q !== 16'h0000) begin bad++; $display("FAIL reset_sq act=%h exp=0000", s_q); end
        #1 clr = 1'b1;
        tick();
        total++; if (w_q !== 16'h0000) begin bad++; $display("FAIL reset_hold act=%h exp=0000", w_q); end
    endtask

    task automatic test_ripple_up();
        enable = 1'b1; load = 1'b1; up = 1'b1; ci = 1'b1; d = 16'h0199;
        tick();
        total++; if (w_q !== 16'h0199) begin bad++; $display("FAIL up_load act=%h exp=0199", w_q); end
        load = 1'b0; #1;
        total++; if (w_tc !== 1'b0) begin bad++; $display("FAIL up_tc_nonterm act=%b exp=0", w_tc); end
        tick();
        total++; if (w_q !== 16'h0200) begin bad++; $display("FAIL up_ripple act=%h exp=0200", w_q); end
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL up_ripple_co act=%b exp=0", w_co); end
        load = 1'b1; d = 16'h9999;
        tick();
        load = 1'b0; #1;
        total++; if (w_tc !== 1'b1) begin bad++; $display("FAIL up_tc_term act=%b exp=1", w_tc); end
        total++; if (s_tc !== 1'b1) begin bad++; $display("FAIL up_stc_term act=%b exp=1", s_tc); end
        tick();
        total++; if (w_q !== 16'h0000) begin bad++; $display("FAIL up_wrap act=%h exp=0000", w_q); end
        total++; if (w_co !== 1'b1) begin bad++; $display("FAIL up_wrap_co act=%b exp=1", w_co); end
        total++; if (s_q !== 16'h9999) begin bad++; $display("FAIL up_sat act=%h exp=9999", s_q); end
        enable = 1'b0;
        tick();
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL up_co_drop act=%b exp=0", w_co); end
        total++; if (w_q !== 16'h0000) begin bad++; $display("FAIL up_en_hold act=%h exp=0000", w_q); end
    endtask

    task automatic test_borrow_down();
        enable = 1'b1; load = 1'b1; d = 16'h1000;
        tick();
        load = 1'b0; up = 1'b0;
        tick();
        total++; if (w_q !== 16'h0999) begin bad++; $display("FAIL dn_borrow act=%h exp=0999", w_q); end
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL dn_borrow_co act=%b exp=0", w_co); end
        load = 1'b1; d = 16'h0000;
        tick();
        load = 1'b0; #1;
        total++; if (w_tc !== 1'b1) begin bad++; $display("FAIL dn_tc act=%b exp=1", w_tc); end
        tick();
        total++; if (w_q !== 16'h9999) begin bad++; $display("FAIL dn_wrap act=%h exp=9999", w_q); end
        total++; if (w_co !== 1'b1) begin bad++; $display("FAIL dn_wrap_co act=%b exp=1", w_co); end
        total++; if (s_q !== 16'h0000) begin bad++; $display("FAIL dn_sat act=%h exp=0000", s_q); end
        total++; if (s_co !== 1'b1) begin bad++; $display("FAIL dn_sat_co act=%b exp=1", s_co); end
    endtask

    task automatic test_saturate();
        load = 1'b1; up = 1'b1; d = 16'h9999;
        tick();
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL sat_load_co act=%b exp=0", w_co); end
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (s_q !== 16'h9999) begin bad++; $display("FAIL sat_q%0d act=%h exp=9999", i, s_q); end
            total++; if (s_co !== 1'b1) begin bad++; $display("FAIL sat_co%0d act=%b exp=1", i, s_co); end
        end
        total++; if (w_q !== 16'h0002) begin bad++; $display("FAIL sat_wrapdut act=%h exp=0002", w_q); end
        up = 1'b0;
        tick();
        total++; if (s_q !== 16'h9998) begin bad++; $display("FAIL sat_down act=%h exp=9998", s_q); end
        total++; if (s_co !== 1'b0) begin bad++; $display("FAIL sat_down_co act=%b exp=0", s_co); end
    endtask

    task automatic test_invalid_load();
        load = 1'b1; ci = 1'b1; d = 16'h3A7F;
        tick();
        total++; if (w_q !== 16'h3979) begin bad++; $display("FAIL inv_clamp act=%h exp=3979", w_q); end
        total++; if (w_le !== 1'b1) begin bad++; $display("FAIL inv_le act=%b exp=1", w_le); end
        enable = 1'b0; load = 1'b0;
        tick();
        total++; if (w_le !== 1'b1) begin bad++; $display("FAIL inv_le_hold act=%b exp=1", w_le); end
        enable = 1'b1; load = 1'b1; d = 16'h0042;
        tick();
        total++; if (w_q !== 16'h0042) begin bad++; $display("FAIL inv_reload act=%h exp=0042", w_q); end
        total++; if (w_le !== 1'b0) begin bad++; $display("FAIL inv_le_clear act=%b exp=0", w_le); end
        enable = 1'b0; d = 16'h1234;
        tick();
        total++; if (w_q !== 16'h0042) begin bad++; $display("FAIL inv_en_gate act=%h exp=0042", w_q); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; load = 1'b1; d = 16'h0123;
        tick();
        load = 1'b0; up = 1'b1; ci = 1'b1;
        tick();
        tick();
        total++; if (w_q !== 16'h0125) begin bad++; $display("FAIL mid_pre act=%h exp=0125", w_q); end
        #3 clr = 1'b0;
        #1;
        total++; if (w_q !== 16'h0000) begin bad++; $display("FAIL mid_async_q act=%h exp=0000", w_q); end
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL mid_async_co act=%b exp=0", w_co); end
        clr = 1'b1;
        tick();
        total++; if (w_q !== 16'h0001) begin bad++; $display("FAIL mid_resume act=%h exp=0001", w_q); end
        ci = 1'b0;
        tick();
        total++; if (w_q !== 16'h0001) begin bad++; $display("FAIL ci_gate act=%h exp=0001", w_q); end
        total++; if (w_co !== 1'b0) begin bad++; $display("FAIL ci_gate_co act=%b exp=0", w_co); end
        ci = 1'b1; enable = 1'b0;
    endtask

    task automatic test_cascade();
        c_en = 1'b1; c_load = 1'b1; c_up = 1'b1; c_dlo = 8'h99; c_dhi = 8'h05;
`ifdef BCD_COUNTER_MATCH_EN
        c_mlo = 8'h00; c_mhi = 8'h06;
`endif
        tick();
        total++; if ({hi_q, lo_q} !== 16'h0599) begin bad++; $display("FAIL cas_load act=%h exp=0599", {hi_q, lo_q}); end
        c_load = 1'b0; #1;
        total++; if (lo_tc !== 1'b1) begin bad++; $display("FAIL cas_lo_tc act=%b exp=1", lo_tc); end
        total++; if (hi_tc !== 1'b0) begin bad++; $display("FAIL cas_hi_tc act=%b exp=0", hi_tc); end
        tick();
        total++; if ({hi_q, lo_q} !== 16'h0600) begin bad++; $display("FAIL cas_step act=%h exp=0600", {hi_q, lo_q}); end
        total++; if ({hi_co, lo_co} !== 2'b01) begin bad++; $display("FAIL cas_co act=%b exp=01", {hi_co, lo_co}); end
        total++; if ({hi_le, lo_le} !== 2'b00) begin bad++; $display("FAIL cas_le act=%b exp=00", {hi_le, lo_le}); end
`ifdef BCD_COUNTER_MATCH_EN
        total++; if ({hi_match, lo_match} !== 2'b11) begin bad++; $display("FAIL cas_match act=%b exp=11", {hi_match, lo_match}); end
`endif
        tick();
        total++; if ({hi_q, lo_q} !== 16'h0601) begin bad++; $display("FAIL cas_step2 act=%h exp=0601", {hi_q, lo_q}); end
`ifdef BCD_COUNTER_MATCH_EN
        total++; if ({hi_match, lo_match} !== 2'b10) begin bad++; $display("FAIL cas_match2 act=%b exp=10", {hi_match, lo_match}); end
`endif
        c_en = 1'b0;
    endtask

    initial begin
        clr = 1'b0; enable = 1'b0; load = 1'b0; up = 1'b1; ci = 1'b1; d = '0;
        c_en = 1'b0; c_load = 1'b0; c_up = 1'b1; c_dlo = '0; c_dhi = '0;
`ifdef BCD_COUNTER_MATCH_EN
        mv = '0; c_mlo = '0; c_mhi = '0;
`endif
        test_reset();
        test_ripple_up();
        test_borrow_down();
        test_saturate();
        test_invalid_load();
        test_reset_mid();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
